gs_div_prenorm: RTL
===================

Name: gs_div_prenorm

Overview:
- Operand pre-normalizer that sits directly upstream of the Goldschmidt divider core.
- Accepts a Q9.23 dividend/divisor pair over a valid/ready handshake.
- Bit-serially scales the divisor into [0.5, 1) so the core's reciprocal seed and iterations converge quickly.
- Presents the divider with a normalized operand pair plus a signed shift count; the downstream result stage applies the count to the quotient.

Parameters:
- WIDTH, 32, total operand width.
- FRAC, 23, fractional bits; bit FRAC-1 is the 0.5 weight.
- SHW, 6, signed shift-count width; must hold the range -(FRAC-1) to +(WIDTH-FRAC).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- dividend  in  WIDTH  Q9.23 unsigned dividend.
- divisor  in  WIDTH  Q9.23 unsigned divisor.
- out_valid  out  1  normalized pair valid; doubles as the divider start request.
- out_ready  in  1  divider accepts the pair.
- norm_dividend  out  WIDTH  captured dividend, never shifted.
- norm_divisor  out  WIDTH  divisor scaled into [0.5, 1).
- shift_cnt  out  SHW  signed count. Positive = divisor was shifted right; the true quotient is the core result >> shift_cnt. Negative = the core result must be shifted left by -shift_cnt.
- div_zero  out  1  divisor was zero.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - out_valid, norm_dividend, norm_divisor, shift_cnt, div_zero all = 0.
- in_ready = (state == IDLE). It reads 1 after reset release.
- IDLE:
  - On in_valid & in_ready, capture dividend into norm_dividend and divisor into norm_divisor.
  - Clear shift_cnt and div_zero; go to SHIFT.
- SHIFT: exactly one action per cycle, evaluated in this priority order:
  1. norm_divisor == 0: set div_zero = 1, go to DONE. (Only when GSDIV_ZERO_DETECT_EN is defined; see Optional Feature.)
  2. Any bit in norm_divisor[WIDTH-1:FRAC] is set: shift right by 1, shift_cnt += 1.
  3. Else, if norm_divisor[FRAC-1] == 0: shift left by 1, shift_cnt -= 1.
  4. Else (normalized): go to DONE.
- DONE:
  - out_valid = 1; all outputs are held stable while out_ready = 0.
  - On out_ready, deassert out_valid and go to IDLE.
  - No new operands are accepted in the same cycle; the next accept occurs one cycle later at the earliest.
- Latency: with k = |final shift_cnt|, operands are accepted at edge 0 and out_valid is seen after edge k+1.
  - Worst case 23 cycles (divisor = 1 LSB).
  - Right-shift worst case 10 cycles (divisor MSB set).
- Left shifts never lose bits, because they only occur while bits above FRAC-1 are zero.
  - Right shifts never occur once the divisor is below 1.0.
  - Therefore the divisor is lossless except for LSBs dropped by right shifts.
- in_valid is ignored in SHIFT and DONE.
- out_ready is ignored outside DONE.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately; the operation is lost and nothing is emitted.
- Arithmetic is purely logical shifting; no rounding.

Optional Feature:
- Macro: GSDIV_ZERO_DETECT_EN.
- Defined: a zero divisor goes to DONE after exactly one SHIFT cycle, with div_zero = 1, shift_cnt = 0, norm_divisor = 0, and out_valid after edge 1.
- Undefined:
  - div_zero is tied to 0.
  - A zero divisor would cause left shifts without bound, so shift_cnt stops at -(FRAC) and the block forces DONE with norm_divisor = 0.
  - Upstream is responsible for never sending a zero divisor.

Test Plan:
- Divisor 0x00800000 (1.0), dividend 0x01800000 -> norm_divisor 0x00400000, shift_cnt +1, norm_dividend 0x01800000, out_valid after edge 2.
- Divisor 0x00400000 (0.5) -> norm_divisor 0x00400000, shift_cnt 0, out_valid after edge 1.
- Divisor 0x80000000 -> norm_divisor 0x00400000, shift_cnt +9, out_valid after edge 10.
- Divisor 0x00000001 -> norm_divisor 0x00400000, shift_cnt -22, out_valid after edge 23.
- out_ready held 0 for 5 cycles in DONE, with in_valid pulsed during that time:
  - outputs stay stable; in_ready stays 0; the second pair is not captured.
  - Raise out_ready: the block returns to IDLE and in_ready = 1 the next cycle.
- Zero divisor with GSDIV_ZERO_DETECT_EN -> div_zero 1, shift_cnt 0, out_valid after edge 1.
- Reset driven low mid-SHIFT -> outputs 0 asynchronously and in_ready 1 after release.

Source files
------------

// File: rtl/gs_div_prenorm.sv
// gs_div_prenorm: operand pre-normalizer for the Goldschmidt divider core.
// Captures a Q9.23 dividend/divisor pair, shifts the divisor one bit per cycle
// into [0.5, 1) and reports the signed shift count for the result stage.
// Optional macro: GSDIV_ZERO_DETECT_EN (flag a zero divisor in one SHIFT cycle).
module gs_div_prenorm #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 23,
  parameter int unsigned SHW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] norm_dividend,
  output logic [WIDTH-1:0] norm_divisor,
  output logic [SHW-1:0]   shift_cnt,
  output logic             div_zero
);

  // Count value at which a zero divisor is forced out when detection is off.
  localparam logic [SHW-1:0] L_CNT_FLOOR = SHW'(-int'(FRAC));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_norm_dividend;
  logic [WIDTH-1:0] r_norm_divisor;
  logic [SHW-1:0]   r_shift_cnt;

  logic             w_above_one;
  logic             w_half_set;
  logic             w_cnt_floor;

  assign w_above_one = |r_norm_divisor[WIDTH-1:FRAC];
  assign w_half_set  = r_norm_divisor[FRAC-1];
  assign w_cnt_floor = (r_shift_cnt == L_CNT_FLOOR);

`ifdef GSDIV_ZERO_DETECT_EN
  logic r_div_zero;
  logic w_is_zero;

  assign w_is_zero = (r_norm_divisor == '0);
  assign div_zero  = r_div_zero;
`else
  assign div_zero  = 1'b0;
`endif

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign norm_dividend = r_norm_dividend;
  assign norm_divisor  = r_norm_divisor;
  assign shift_cnt     = r_shift_cnt;

  // Capture, one-bit-per-cycle normalization and output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_norm_dividend <= '0;
      r_norm_divisor  <= '0;
      r_shift_cnt     <= '0;
`ifdef GSDIV_ZERO_DETECT_EN
      r_div_zero      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_norm_dividend <= dividend;
            r_norm_divisor  <= divisor;
            r_shift_cnt     <= '0;
`ifdef GSDIV_ZERO_DETECT_EN
            r_div_zero      <= 1'b0;
`endif
            r_in_ready      <= 1'b0;
            r_state         <= S_SHIFT;
          end
        end

        S_SHIFT: begin
`ifdef GSDIV_ZERO_DETECT_EN
          if (w_is_zero) begin
            r_div_zero  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else
`endif
          if (w_above_one) begin
            r_norm_divisor <= {1'b0, r_norm_divisor[WIDTH-1:1]};
            r_shift_cnt    <= r_shift_cnt + SHW'(1);
          end else if (!w_half_set) begin
            // Only a zero divisor can reach the floor; stop it from spinning.
            if (w_cnt_floor) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_norm_divisor <= {r_norm_divisor[WIDTH-2:0], 1'b0};
              r_shift_cnt    <= r_shift_cnt - SHW'(1);
            end
          end else begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
